// File: rtl/pwm_deadtime_modulator_if.sv
// Signal bundle between the carrier/duty source and the dead-time PWM leg.
// The source side drives carrier, trigger, duty and control; the modulator
// side returns the registered gate pair and the duty-update pulse.
interface pwm_deadtime_modulator_if #(
    parameter int Width     = 7,
    parameter int DeadWidth = 4
);
    logic [Width-1:0]     carrier_i;
    logic                 trigger_i;
    logic [Width-1:0]     duty_i;
    logic                 duty_valid_i;
    logic [DeadWidth-1:0] dead_time_i;
    logic                 enable_i;
    logic                 gate_hi_o;
    logic                 gate_lo_o;
    logic                 update_o;

    modport master (
        output carrier_i,
        output trigger_i,
        output duty_i,
        output duty_valid_i,
        output dead_time_i,
        output enable_i,
        input  gate_hi_o,
        input  gate_lo_o,
        input  update_o
    );

    modport slave (
        input  carrier_i,
        input  trigger_i,
        input  duty_i,
        input  duty_valid_i,
        input  dead_time_i,
        input  enable_i,
        output gate_hi_o,
        output gate_lo_o,
        output update_o
    );
endinterface

// File: rtl/pwm_deadtime_modulator.sv
// Single-leg centre-aligned PWM modulator with dead-time insertion.
// A double-buffered duty is compared against the triangular carrier; the
// resulting reference drives a complementary gate pair through a small FSM
// that guarantees a programmable both-off interval at every commutation.
module pwm_deadtime_modulator #(
    parameter int Width     = 7,
    parameter int DeadWidth = 4
) (
    input logic                    clk_i,
    input logic                    rst_i,
    pwm_deadtime_modulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DEAD = 2'd3
    } state_t;

    logic [Width-1:0]     duty_shadow;
    logic                 pending;
    logic [Width-1:0]     duty_active;
    logic                 update;
    logic                 ref_q;

    state_t               state;
    state_t               state_next;
    logic [DeadWidth-1:0] dcnt;
    logic [DeadWidth-1:0] dcnt_next;
    logic                 target;
    logic                 target_next;
    logic                 gate_hi;
    logic                 gate_lo;
    logic                 gate_hi_next;
    logic                 gate_lo_next;

    logic                 dead_zero;
    logic [DeadWidth-1:0] dead_reload;

    // Shadow capture and turnaround-synchronous activation of the duty value
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            duty_shadow <= '0;
            pending     <= 1'b0;
            duty_active <= '0;
            update      <= 1'b0;
        end else begin
            update <= 1'b0;
            if (bus.duty_valid_i && bus.trigger_i) begin
                // A strobe landing on the turnaround goes live immediately
                duty_shadow <= bus.duty_i;
                duty_active <= bus.duty_i;
                pending     <= 1'b0;
                update      <= 1'b1;
            end else begin
                if (bus.duty_valid_i) begin
                    duty_shadow <= bus.duty_i;
                    pending     <= 1'b1;
                end
                if (bus.trigger_i && pending) begin
                    duty_active <= duty_shadow;
                    pending     <= 1'b0;
                    update      <= 1'b1;
                end
            end
        end
    end

    // Registered carrier-versus-duty compare giving the symmetric PWM reference
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ref_q <= 1'b0;
        end else begin
            ref_q <= (bus.carrier_i < duty_active);
        end
    end

    // A zero setting never loads the counter, so the reload is held at 0
    // rather than wrapping to the maximum count.
    assign dead_zero   = (bus.dead_time_i == '0);
    assign dead_reload = dead_zero ? '0 : (bus.dead_time_i - 1'b1);

    // Gate FSM state, dead-time counter and gate output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            dcnt    <= '0;
            target  <= 1'b0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else begin
            state   <= state_next;
            dcnt    <= dcnt_next;
            target  <= target_next;
            gate_hi <= gate_hi_next;
            gate_lo <= gate_lo_next;
        end
    end

    // Next-state logic: commutate on reference changes, restarting the
    // dead interval whenever the reference moves again while both gates are off
    always_comb begin
        state_next   = state;
        dcnt_next    = dcnt;
        target_next  = target;
        gate_hi_next = 1'b0;
        gate_lo_next = 1'b0;

        if (!bus.enable_i) begin
            state_next = IDLE;
            dcnt_next  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    target_next = ref_q;
                    if (dead_zero) begin
                        state_next   = ref_q ? HI : LO;
                        gate_hi_next = ref_q;
                        gate_lo_next = !ref_q;
                    end else begin
                        state_next = DEAD;
                        dcnt_next  = dead_reload;
                    end
                end

                HI: begin
                    if (ref_q) begin
                        gate_hi_next = 1'b1;
                    end else begin
                        target_next = 1'b0;
                        if (dead_zero) begin
                            state_next   = LO;
                            gate_lo_next = 1'b1;
                        end else begin
                            state_next = DEAD;
                            dcnt_next  = dead_reload;
                        end
                    end
                end

                LO: begin
                    if (!ref_q) begin
                        gate_lo_next = 1'b1;
                    end else begin
                        target_next = 1'b1;
                        if (dead_zero) begin
                            state_next   = HI;
                            gate_hi_next = 1'b1;
                        end else begin
                            state_next = DEAD;
                            dcnt_next  = dead_reload;
                        end
                    end
                end

                DEAD: begin
                    if (ref_q != target) begin
                        // Reference pulse shorter than the dead time: swallow it
                        target_next = ref_q;
                        dcnt_next   = dead_reload;
                    end else if (dcnt == '0) begin
                        state_next   = target ? HI : LO;
                        gate_hi_next = target;
                        gate_lo_next = !target;
                    end else begin
                        dcnt_next = dcnt - 1'b1;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.gate_hi_o = gate_hi;
    assign bus.gate_lo_o = gate_lo;
    assign bus.update_o  = update;

endmodule

// File: tb/tb_pwm_deadtime_modulator.sv
// Directed bench for the dead-time PWM leg. A local triangular carrier
// (0..127..1, period 254, trigger at both turnarounds) stands in for the
// upstream generator.
module tb_pwm_deadtime_modulator;

    localparam int Width     = 7;
    localparam int DeadWidth = 4;
    localparam int Period    = 254;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int phase  = 0;
    logic trig_edge = 1'b0;

    pwm_deadtime_modulator_if #(.Width(Width), .DeadWidth(DeadWidth)) bus();

    pwm_deadtime_modulator #(.Width(Width), .DeadWidth(DeadWidth)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Gate pair must never conduct together
    always @(negedge clk) begin
        check_val("gate_overlap", int'(bus.gate_hi_o & bus.gate_lo_o), 0);
    end

    // One clock: outputs are read 1 time unit after the edge, then the next
    // carrier sample and trigger are presented and the duty strobe is dropped.
    task automatic step();
        @(posedge clk);
        #1;
        trig_edge        = bus.trigger_i;
        bus.duty_valid_i = 1'b0;
        phase            = (phase == Period - 1) ? 0 : phase + 1;
        bus.carrier_i    = (phase <= 127) ? Width'(phase) : Width'(Period - phase);
        bus.trigger_i    = (bus.carrier_i == 0) || (bus.carrier_i == 127);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic goto_phase(input int p);
        for (int i = 0; i < Period; i++) begin
            if (phase == p) break;
            step();
        end
    endtask

    task automatic set_duty(input int d);
        bus.duty_i       = Width'(d);
        bus.duty_valid_i = 1'b1;
        step();
        run(2 * Period);
    endtask

    // One full carrier period starting at the top turnaround
    task automatic measure(output int hi_n, output int lo_n, output int off_n,
                           output int max_off, output int lag_hi, output int lag_lo);
        int run_len;
        int hi_fall;
        int lo_fall;
        logic ph, pl, h, l;
        hi_n = 0; lo_n = 0; off_n = 0; max_off = 0;
        lag_hi = -1; lag_lo = -1;
        run_len = 0; hi_fall = -1000; lo_fall = -1000;
        goto_phase(127);
        ph = bus.gate_hi_o;
        pl = bus.gate_lo_o;
        for (int i = 0; i < Period; i++) begin
            step();
            h = bus.gate_hi_o;
            l = bus.gate_lo_o;
            if (h) hi_n++;
            if (l) lo_n++;
            if (!h && !l) begin
                off_n++;
                run_len++;
                if (run_len > max_off) max_off = run_len;
            end else begin
                run_len = 0;
            end
            if (ph && !h) hi_fall = i;
            if (pl && !l) lo_fall = i;
            if (!ph && h) lag_hi = i - lo_fall;
            if (!pl && l) lag_lo = i - hi_fall;
            ph = h;
            pl = l;
        end
    endtask

    initial begin
        int hi_n, lo_n, off_n, max_off, lag_hi, lag_lo;
        int found, upd_seen, width, k;

        bus.carrier_i    = '0;
        bus.trigger_i    = 1'b1;
        bus.duty_i       = '0;
        bus.duty_valid_i = 1'b0;
        bus.dead_time_i  = '0;
        bus.enable_i     = 1'b0;

        // Reset state
        rst = 1'b1;
        run(2);
        check_val("rst_gate_hi", bus.gate_hi_o, 0);
        check_val("rst_gate_lo", bus.gate_lo_o, 0);
        check_val("rst_update", bus.update_o, 0);
        check_val("rst_duty_active", dut.duty_active, 0);
        rst = 1'b0;

        // 1: D=64, no dead time
        bus.enable_i    = 1'b1;
        bus.dead_time_i = 4'd0;
        set_duty(64);
        measure(hi_n, lo_n, off_n, max_off, lag_hi, lag_lo);
        check_val("d64_dt0_hi", hi_n, 127);
        check_val("d64_dt0_lo", lo_n, 127);
        check_val("d64_dt0_off", off_n, 0);

        // 2: D=64, dead time 4
        bus.dead_time_i = 4'd4;
        run(Period);
        measure(hi_n, lo_n, off_n, max_off, lag_hi, lag_lo);
        check_val("d64_dt4_hi", hi_n, 123);
        check_val("d64_dt4_lo", lo_n, 123);
        check_val("d64_dt4_off", off_n, 8);
        check_val("d64_dt4_lag_hi", lag_hi, 4);
        check_val("d64_dt4_lag_lo", lag_lo, 4);

        // 3: narrow pulse swallowed, then zero duty
        set_duty(1);
        measure(hi_n, lo_n, off_n, max_off, lag_hi, lag_lo);
        check_val("d1_dt4_hi", hi_n, 0);
        check_val("d1_dt4_lo", lo_n, 249);
        check_val("d1_dt4_gap", max_off, 5);
        set_duty(0);
        measure(hi_n, lo_n, off_n, max_off, lag_hi, lag_lo);
        check_val("d0_lo", lo_n, 254);
        check_val("d0_hi", hi_n, 0);

        // 4: mid-half-period strobe waits for the turnaround
        set_duty(20);
        goto_phase(50);
        bus.duty_i       = 7'd100;
        bus.duty_valid_i = 1'b1;
        step();
        check_val("strobe_active_held", dut.duty_active, 20);
        check_val("strobe_pending", dut.pending, 1);
        found = 0;
        upd_seen = 0;
        for (int i = 0; i < Period; i++) begin
            step();
            if (trig_edge) begin
                found = 1;
                break;
            end
            if (bus.update_o) upd_seen++;
        end
        check_val("trigger_reached", found, 1);
        check_val("no_early_update", upd_seen, 0);
        check_val("update_after_trigger", bus.update_o, 1);
        check_val("duty_active_new", dut.duty_active, 100);
        step();
        check_val("update_one_cycle", bus.update_o, 0);
        found = 0;
        for (int i = 0; i < 2 * Period; i++) begin
            if (bus.gate_hi_o) begin
                found = 1;
                break;
            end
            step();
        end
        check_val("hi_rise_seen", found, 1);
        width = 0;
        for (int i = 0; i < 2 * Period; i++) begin
            if (!bus.gate_hi_o) break;
            width++;
            step();
        end
        check_val("d100_hi_width", width, 195);

        // 4b: strobe coincident with the trigger bypasses the shadow
        for (int i = 0; i < Period; i++) begin
            if (bus.trigger_i) break;
            step();
        end
        bus.duty_i       = 7'd40;
        bus.duty_valid_i = 1'b1;
        step();
        check_val("bypass_update", bus.update_o, 1);
        check_val("bypass_active", dut.duty_active, 40);
        check_val("bypass_pending", dut.pending, 0);
        found = 0;
        for (int i = 0; i < Period; i++) begin
            step();
            if (trig_edge) begin
                found = 1;
                break;
            end
        end
        check_val("bypass_next_trigger", found, 1);
        check_val("bypass_no_second_update", bus.update_o, 0);

        // 5: disable during HI, re-enable with dead time 6
        found = 0;
        for (int i = 0; i < 2 * Period; i++) begin
            if (bus.gate_hi_o) begin
                found = 1;
                break;
            end
            step();
        end
        check_val("hi_for_disable", found, 1);
        bus.enable_i = 1'b0;
        step();
        check_val("disable_hi", bus.gate_hi_o, 0);
        check_val("disable_lo", bus.gate_lo_o, 0);
        bus.dead_time_i = 4'd6;
        goto_phase(60);
        bus.enable_i = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            k++;
            if (bus.gate_hi_o || bus.gate_lo_o) break;
        end
        check_val("reenable_latency", k, 7);
        check_val("reenable_gate_lo", bus.gate_lo_o, 1);

        // 6a: reset while in DEAD
        bus.enable_i = 1'b0;
        step();
        bus.enable_i = 1'b1;
        run(3);
        check_val("dead_hi_off", bus.gate_hi_o, 0);
        check_val("dead_lo_off", bus.gate_lo_o, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_dead_hi", bus.gate_hi_o, 0);
        check_val("rst_dead_lo", bus.gate_lo_o, 0);
        check_val("rst_dead_update", bus.update_o, 0);
        check_val("rst_dead_duty", dut.duty_active, 0);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            k++;
            if (bus.gate_hi_o || bus.gate_lo_o) break;
        end
        check_val("post_rst_latency", k, 7);

        // 6b: reset while in HI
        set_duty(64);
        found = 0;
        for (int i = 0; i < 2 * Period; i++) begin
            if (bus.gate_hi_o) begin
                found = 1;
                break;
            end
            step();
        end
        check_val("hi_for_reset", found, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_hi_hi", bus.gate_hi_o, 0);
        check_val("rst_hi_lo", bus.gate_lo_o, 0);
        check_val("rst_hi_update", bus.update_o, 0);
        check_val("rst_hi_duty", dut.duty_active, 0);
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime_modulator.md
# pwm_deadtime_modulator

Single-leg PWM modulator with dead-time insertion for the 3LFCC power stage. It sits directly downstream of `signal_generator_0phase`:
- compares the triangular carrier against a double-buffered duty value to produce a symmetric (centre-aligned) PWM reference;
- drives a complementary high/low gate pair;
- guarantees a programmable both-off interval at every commutation.

Duty updates take effect only at carrier turnarounds, so the effective duty never changes mid-half-period.

## Interface
- `Width`, 7: carrier/duty width; must match the carrier generator.
- `DeadWidth`, 4: width of the dead-time setting, in clock cycles.

- `clk_i`  in  1  single system clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `carrier_i`  in  Width  triangular carrier (`count_o` of the generator).
- `trigger_i`  in  1  carrier turnaround pulse (`trigger_o` of the generator).
- `duty_i`  in  Width  requested duty compare value.
- `duty_valid_i`  in  1  one-cycle strobe; captures `duty_i` into the shadow register.
- `dead_time_i`  in  DeadWidth  dead-time in cycles; 0 = no dead time.
- `enable_i`  in  1  0 forces both gates off.
- `gate_hi_o`  out  1  high-side gate, registered.
- `gate_lo_o`  out  1  low-side gate, registered.
- `update_o`  out  1  one-cycle pulse when a new duty becomes active.

## Operation
- **Reset values** (all registers cleared on `rst_i`):
  - `duty_shadow = 0`, `pending = 0`, `duty_active = 0`, `ref_q = 0`;
  - state `IDLE`, `dcnt = 0`, `target = 0`;
  - outputs: `gate_hi_o = gate_lo_o = update_o = 0`.
- **Duty shadow:**
  - When `duty_valid_i` is high: `duty_shadow <= duty_i` and `pending <= 1`.
  - Back-to-back strobes: the last value wins.
- **Duty activation**, on `trigger_i`:
  - If `pending` is set: `duty_active <= duty_shadow`, `pending <= 0`, `update_o <= 1`.
  - If `duty_valid_i` and `trigger_i` are high in the same cycle, `duty_i` bypasses straight into `duty_active`. The shadow is also written, `pending` stays 0, and `update_o` pulses.
  - `trigger_i` with no pending update: nothing changes.
- **Reference:** `ref_q <= (carrier_i < duty_active)`, an unsigned compare.
  - Duty 0 gives a constant 0.
  - With a 0..2^Width−1 carrier (period 2·(2^Width−1) cycles), duty D ≥ 1 gives `ref_q` high for 2D−1 cycles per period.
- **State machine** (`IDLE`, `HI`, `LO`, `DEAD`):
  - `IDLE`: both gates off. When `enable_i` is high: `target <= ref_q`.
    - If `dead_time_i == 0`, go directly to `HI`/`LO`.
    - Otherwise go to `DEAD` with `dcnt <= dead_time_i − 1`.
  - `HI` / `LO`: the matching gate is on. If `ref_q` differs from the current conduction:
    - turn the current gate off and set `target <= ref_q`;
    - go to `DEAD` (`dcnt <= dead_time_i − 1`), or, if `dead_time_i == 0`, swap the gates on the same edge.
  - `DEAD`: both gates off. Checks in priority order:
    1. If `ref_q != target`: `target <= ref_q`, `dcnt <= dead_time_i − 1` (restart).
    2. Else if `dcnt == 0`: enter `target` (`HI` if 1, `LO` if 0) and assert that gate.
    3. Else `dcnt <= dcnt − 1`.
  - `dead_time_i` is sampled only on entry to or restart of `DEAD`.
  - `enable_i == 0` in any state: next state `IDLE`, both gates 0 on the next edge, and `dcnt` is cleared.
- **Invariant:** `gate_hi_o & gate_lo_o` is never 1.
- **Pulse suppression:** a reference pulse no longer than the dead time produces no gate pulse. The off interval is extended instead, because of the restart rule.

## Timing
- Compare latency: `carrier_i` at cycle t → `ref_q` at t+1.
- Commutation: `ref_q` change visible at t+1 → the outgoing gate falls at t+2 → the incoming gate rises at t+2+`dead_time_i`. Both gates are low for exactly `dead_time_i` cycles.
- The compare uses the old duty in the `trigger_i` cycle. The new `duty_active` is used from the next cycle, and `update_o` is high in that same next cycle.
- After `enable_i` rises at cycle t, the first gate asserts at t+1+`dead_time_i`.
- The reset cycle overrides all inputs; outputs take their reset values on the next edge.

## Test plan
Scenarios 1–4 use `Width = 7` and `signal_generator_0phase` as the carrier source (period 254).

1. D = 64, dt = 0, enable = 1, steady state → per 254-cycle period, `gate_hi_o` high 127 cycles and `gate_lo_o` high 127 cycles; never both high, never both low.
2. D = 64, dt = 4 → per period, `gate_hi_o` high 123, `gate_lo_o` high 123, both low 4 cycles at each edge (8 total). Each rising gate lags the other's fall by exactly 4 cycles.
3. D = 1, dt = 4 → `gate_hi_o` never asserts; `gate_lo_o` drops for 5 consecutive cycles once per period. D = 0 → `gate_lo_o` continuously high.
4. Strobe `duty_valid_i` with D = 100 mid-half-period while the active duty is 20 → `duty_active` is unchanged until the next `trigger_i`. `update_o` pulses one cycle after that trigger, and the `gate_hi_o` width becomes 2·100−1−dt. Also cover a strobe coincident with `trigger_i` (bypass path).
5. Drop `enable_i` during `HI` → both gates 0 on the next edge. Re-enable with dt = 6 → first gate asserts 7 cycles after `enable_i` rises.
6. Assert `rst_i` during `DEAD` and during `HI` → all outputs 0 the next cycle and `duty_active` = 0. Throughout every test, a bench assertion checks `!(gate_hi_o && gate_lo_o)`.
